// File: rtl/dir_queue.sv
// Direction input queue: synchronizes raw pushbuttons, filters illegal turns and
// buffers up to DEPTH headings that are consumed one per game tick.
module dir_queue #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               direction_pb,
  input  logic                     tick,
  input  logic                     game_reset,
  output logic [1:0]               direction,
  output logic                     turned,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    prevPb_q;
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    dir_q, dir_d;
  logic          turned_q, turned_d;
  logic          ovf_q, ovf_d;

  logic [3:0] rise;
  logic       pressValid;
  logic [1:0] pressDir;
  logic [1:0] refDir;
  logic       accept, pop, push;

  // History flops keep running through game_reset so a held button is not re-detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prevPb_q <= '0;
    end else begin
      sync_q[0] <= direction_pb;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prevPb_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prevPb_q;

  always_comb begin
    pressValid = 1'b1;
    pressDir   = 2'b00;
    if (rise[3])      pressDir = 2'b11;
    else if (rise[2]) pressDir = 2'b10;
    else if (rise[1]) pressDir = 2'b01;
    else if (rise[0]) pressDir = 2'b00;
    else              pressValid = 1'b0;
  end

  // Same heading or its reverse share bit1, so only an axis change is a legal turn.
  assign refDir = (count_q != '0) ? mem[tail_q - ONE] : dir_q;
  assign accept = pressValid && (pressDir[1] != refDir[1]);
  assign pop    = tick && (count_q != '0);
  assign push   = accept && ((count_q != FULL) || pop);

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    dir_d    = dir_q;
    ovf_d    = ovf_q;
    turned_d = 1'b0;
    if (game_reset) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      dir_d   = 2'b00;
      ovf_d   = 1'b0;
    end else begin
      if (pop) begin
        dir_d    = mem[head_q];
        head_d   = head_q + ONE;
        turned_d = 1'b1;
      end
      if (push) tail_d = tail_q + ONE;
      if (accept && (count_q == FULL) && !pop) ovf_d = 1'b1;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dir_q    <= 2'b00;
      turned_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      turned_q <= turned_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is never visible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !game_reset) mem[tail_q] <= pressDir;
  end

  assign direction = dir_q;
  assign turned    = turned_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule
